// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset-release sequencer.
package reset_seq_pkg;

  localparam int unsigned CNT_W           = 16;
  localparam int unsigned DEF_NUM_STAGES  = 4;
  localparam int unsigned DEF_STAGE_DELAY = 16;
  localparam int unsigned DEF_ACK_TIMEOUT = 255;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RELEASE,
    ST_WAIT_ACK,
    ST_GAP,
    ST_RUN,
    ST_FAULT
  } state_e;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Level synchronizer for the fabric reset; output is the last flop of the chain.
module reset_sync #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d};
    end
  end

  assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/reset_stage_sequencer.sv
// Releases NUM_STAGES reset domains in ascending order, waiting for each
// stage's acknowledge and a settle gap before releasing the next one.
module reset_stage_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = DEF_NUM_STAGES,
  parameter int unsigned STAGE_DELAY = DEF_STAGE_DELAY,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FABRIC_RESET_N,
  input  logic [NUM_STAGES-1:0] STAGE_ACK,
  output logic [NUM_STAGES-1:0] STAGE_RESET_N,
  output logic                  SYS_READY,
  output logic                  FAULT,
  output logic [2:0]            CUR_STAGE
);

  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [2:0]       LAST_STAGE   = 3'(NUM_STAGES - 1);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    fab_ok;
  logic [NUM_STAGES-1:0]   stage_bit;
  logic                    ack_cur;

  reset_sync #(
    .DEPTH(SYNC_STAGES)
  ) u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (FABRIC_RESET_N),
    .q   (fab_ok)
  );

  // Only the acknowledge of the stage currently being released is looked at,
  // so early acknowledges from unreleased stages have no effect.
  assign stage_bit = NUM_STAGES'(1) << CUR_STAGE;
  assign ack_cur   = |(STAGE_ACK & stage_bit);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      CUR_STAGE     <= '0;
      STAGE_RESET_N <= '0;
      SYS_READY     <= 1'b0;
      FAULT         <= 1'b0;
    end else if (!fab_ok) begin
      // Losing the fabric reset collapses every state, FAULT included, to IDLE.
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      CUR_STAGE     <= '0;
      STAGE_RESET_N <= '0;
      SYS_READY     <= 1'b0;
      FAULT         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q         <= '0;
          CUR_STAGE     <= '0;
          STAGE_RESET_N <= '0;
          SYS_READY     <= 1'b0;
          state_q       <= ST_SETTLE;
        end

        ST_SETTLE: begin
          if (cnt_q == DELAY_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_RELEASE;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end

        ST_RELEASE: begin
          STAGE_RESET_N <= STAGE_RESET_N | stage_bit;
          cnt_q         <= '0;
          state_q       <= ST_WAIT_ACK;
        end

        // An acknowledge in the expiry cycle wins over the timeout.
        ST_WAIT_ACK: begin
          if (ack_cur) begin
            cnt_q <= '0;
            if (CUR_STAGE == LAST_STAGE) begin
              SYS_READY <= 1'b1;
              state_q   <= ST_RUN;
            end else begin
              state_q <= ST_GAP;
            end
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_q         <= '0;
            STAGE_RESET_N <= '0;
            FAULT         <= 1'b1;
            state_q       <= ST_FAULT;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end

        ST_GAP: begin
          if (cnt_q == DELAY_LAST) begin
            cnt_q     <= '0;
            CUR_STAGE <= CUR_STAGE + 3'd1;
            state_q   <= ST_RELEASE;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end

        ST_RUN: begin
          if (STAGE_ACK != '1) begin
            STAGE_RESET_N <= '0;
            SYS_READY     <= 1'b0;
            FAULT         <= 1'b1;
            state_q       <= ST_FAULT;
          end
        end

        ST_FAULT: begin
          STAGE_RESET_N <= '0;
          SYS_READY     <= 1'b0;
          FAULT         <= 1'b1;
        end

        default: begin
          state_q       <= ST_IDLE;
          cnt_q         <= '0;
          STAGE_RESET_N <= '0;
          SYS_READY     <= 1'b0;
          FAULT         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_stage_sequencer.sv
// Directed bench for reset_stage_sequencer at the default parameter set.
module tb_reset_stage_sequencer;

  logic       clk;
  logic       rst;
  logic       fabric_reset_n;
  logic [3:0] stage_ack;
  logic [3:0] stage_reset_n;
  logic       sys_ready;
  logic       fault;
  logic [2:0] cur_stage;

  int unsigned n_total;
  int unsigned n_pass;

  // Acknowledge model: each stage acks 3 cycles after release unless disabled.
  int         rc [4];
  logic [3:0] ack_en;
  logic [3:0] ack_frc;

  reset_stage_sequencer #(
    .NUM_STAGES (4),
    .STAGE_DELAY(16),
    .ACK_TIMEOUT(255),
    .SYNC_STAGES(2)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .FABRIC_RESET_N(fabric_reset_n),
    .STAGE_ACK     (stage_ack),
    .STAGE_RESET_N (stage_reset_n),
    .SYS_READY     (sys_ready),
    .FAULT         (fault),
    .CUR_STAGE     (cur_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive_ack();
    for (int i = 0; i < 4; i++)
      stage_ack[i] = ((rc[i] >= 3) && ack_en[i]) || ack_frc[i];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      rc[i] = stage_reset_n[i] ? ((rc[i] < 3) ? rc[i] + 1 : rc[i]) : 0;
    drive_ack();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic go_idle();
    fabric_reset_n = 1'b0;
    ack_en  = 4'hF;
    ack_frc = 4'h0;
    drive_ack();
    run(4);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    for (int i = 0; i < 4; i++) rc[i] = 0;
    ack_en  = 4'hF;
    ack_frc = 4'h0;
    stage_ack      = 4'h0;
    rst            = 1'b1;
    fabric_reset_n = 1'b0;
    run(3);
    chk("rst_srn",   16'(stage_reset_n), 16'h0);
    chk("rst_ready", 16'(sys_ready),     16'h0);
    chk("rst_fault", 16'(fault),         16'h0);
    chk("rst_cur",   16'(cur_stage),     16'h0);
    rst = 1'b0;
    run(2);

    // Nominal sequence; first edge after this assignment is cycle 0.
    fabric_reset_n = 1'b1;
    run(19);
    chk("nom_c18_srn", 16'(stage_reset_n), 16'h0);
    run(1);
    chk("nom_c19_srn", 16'(stage_reset_n), 16'h1);
    chk("nom_c19_cur", 16'(cur_stage),     16'h0);
    run(19);
    chk("nom_c38_srn", 16'(stage_reset_n), 16'h1);
    run(1);
    chk("nom_c39_srn", 16'(stage_reset_n), 16'h3);
    chk("nom_c39_cur", 16'(cur_stage),     16'h1);
    run(20);
    chk("nom_c59_srn", 16'(stage_reset_n), 16'h7);
    run(20);
    chk("nom_c79_srn",   16'(stage_reset_n), 16'hF);
    chk("nom_c79_cur",   16'(cur_stage),     16'h3);
    chk("nom_c79_ready", 16'(sys_ready),     16'h0);
    run(3);
    chk("nom_c82_ready", 16'(sys_ready), 16'h1);
    chk("nom_c82_fault", 16'(fault),     16'h0);

    // Acknowledge loss in RUN.
    run(4);
    ack_en[3] = 1'b0;
    drive_ack();
    run(1);
    chk("loss_fault", 16'(fault),         16'h1);
    chk("loss_ready", 16'(sys_ready),     16'h0);
    chk("loss_srn",   16'(stage_reset_n), 16'h0);
    run(5);
    chk("loss_hold", 16'(fault), 16'h1);
    fabric_reset_n = 1'b0;
    run(2);
    chk("loss_fab_c1", 16'(fault), 16'h1);
    run(1);
    chk("loss_clear", 16'(fault), 16'h0);
    go_idle();

    // Timeout on stage 2.
    ack_en[2] = 1'b0;
    drive_ack();
    fabric_reset_n = 1'b1;
    run(60);
    chk("to_c59_srn", 16'(stage_reset_n), 16'h7);
    run(254);
    chk("to_c313_fault", 16'(fault), 16'h0);
    run(1);
    chk("to_c314_fault", 16'(fault),         16'h1);
    chk("to_c314_srn",   16'(stage_reset_n), 16'h0);
    run(10);
    chk("to_hold", 16'(fault), 16'h1);
    fabric_reset_n = 1'b0;
    run(3);
    chk("to_clear", 16'(fault), 16'h0);
    go_idle();

    // Ack exactly at timeout expiry, plus an early ack from unreleased stage 3.
    ack_en[2] = 1'b0;
    drive_ack();
    fabric_reset_n = 1'b1;
    run(60);
    chk("bnd_c59_srn", 16'(stage_reset_n), 16'h7);
    ack_frc[3] = 1'b1;
    drive_ack();
    run(200);
    chk("bnd_early_srn", 16'(stage_reset_n), 16'h7);
    chk("bnd_early_cur", 16'(cur_stage),     16'h2);
    ack_frc[3] = 1'b0;
    drive_ack();
    run(54);
    ack_frc[2] = 1'b1;
    drive_ack();
    run(1);
    chk("bnd_c314_fault", 16'(fault),         16'h0);
    chk("bnd_c314_srn",   16'(stage_reset_n), 16'h7);
    run(17);
    chk("bnd_c331_srn", 16'(stage_reset_n), 16'hF);
    chk("bnd_c331_cur", 16'(cur_stage),     16'h3);
    run(3);
    chk("bnd_ready", 16'(sys_ready), 16'h1);
    go_idle();

    // Abort during the gap after stage 1, then full resequence.
    fabric_reset_n = 1'b1;
    run(46);
    chk("abt_c45_srn", 16'(stage_reset_n), 16'h3);
    fabric_reset_n = 1'b0;
    run(2);
    chk("abt_c47_srn", 16'(stage_reset_n), 16'h3);
    run(1);
    chk("abt_c48_srn", 16'(stage_reset_n), 16'h0);
    chk("abt_c48_cur", 16'(cur_stage),     16'h0);
    fabric_reset_n = 1'b1;
    run(19);
    chk("abt_re_c18_srn", 16'(stage_reset_n), 16'h0);
    run(1);
    chk("abt_re_c19_srn", 16'(stage_reset_n), 16'h1);
    run(63);
    chk("abt_re_ready", 16'(sys_ready), 16'h1);
    go_idle();

    // RST pulse while waiting for stage 2.
    ack_en[2] = 1'b0;
    drive_ack();
    fabric_reset_n = 1'b1;
    run(61);
    chk("rp_pre_srn", 16'(stage_reset_n), 16'h7);
    rst = 1'b1;
    run(1);
    chk("rp_srn",   16'(stage_reset_n), 16'h0);
    chk("rp_ready", 16'(sys_ready),     16'h0);
    chk("rp_fault", 16'(fault),         16'h0);
    chk("rp_cur",   16'(cur_stage),     16'h0);
    rst = 1'b0;
    run(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reset_stage_sequencer.md
RESET_STAGE_SEQUENCER -- requirements
Module: reset_stage_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4, number of ordered reset domains released (range 1..8).
REQ-002 Parameter STAGE_DELAY, default 16, settle cycles before first release and between releases (range 1..65535).
REQ-003 Parameter ACK_TIMEOUT, default 255, maximum cycles from a stage release to its acknowledge (range 1..65535).
REQ-004 Parameter SYNC_STAGES, default 2, synchronizer depth for FABRIC_RESET_N (range 2..4).
REQ-005 CLK  input  1  sole clock of the block.
REQ-006 RST  input  1  synchronous, active-high reset.
REQ-007 FABRIC_RESET_N  input  1  active-low fabric reset from the upstream reset generator; may be asynchronous to CLK.
REQ-008 STAGE_ACK  input  NUM_STAGES  per-stage "out of reset and ready" acknowledge, level, CLK domain.
REQ-009 STAGE_RESET_N  output  NUM_STAGES  per-stage active-low reset, registered.
REQ-010 SYS_READY  output  1  high when all stages are released and acknowledged.
REQ-011 FAULT  output  1  high while sequencing is aborted by a timeout or an acknowledge loss.
REQ-012 CUR_STAGE  output  3  index of the stage being released or last released, registered.

Function
REQ-013 FABRIC_RESET_N shall pass through SYNC_STAGES flops to form fab_ok; no other logic shall sample it.
REQ-014 FSM states: IDLE, SETTLE, RELEASE, WAIT_ACK, GAP, RUN, FAULT.
REQ-015 IDLE: all STAGE_RESET_N=0, CUR_STAGE=0; go to SETTLE when fab_ok=1.
REQ-016 SETTLE: count exactly STAGE_DELAY cycles with fab_ok=1, then go to RELEASE.
REQ-017 RELEASE (one cycle): set STAGE_RESET_N[CUR_STAGE]=1 and go to WAIT_ACK with the timeout counter cleared.
REQ-018 WAIT_ACK: on STAGE_ACK[CUR_STAGE]=1, go to GAP if CUR_STAGE<NUM_STAGES-1, otherwise go to RUN.
REQ-019 WAIT_ACK: if ACK_TIMEOUT cycles elapse without the acknowledge, go to FAULT; an acknowledge arriving in the cycle the counter expires is accepted.
REQ-020 GAP: count STAGE_DELAY cycles, increment CUR_STAGE, then go to RELEASE.
REQ-021 Released stages shall stay released; release order shall be strictly ascending index, one stage at a time.
REQ-022 RUN: SYS_READY=1; any STAGE_ACK bit dropping to 0 shall cause a transition to FAULT.
REQ-023 FAULT: all STAGE_RESET_N=0, SYS_READY=0, FAULT=1; leave to IDLE only when fab_ok=0 (FAULT clears on that transition).
REQ-024 fab_ok=0 in SETTLE, RELEASE, WAIT_ACK, GAP or RUN shall move to IDLE the next cycle, with all STAGE_RESET_N=0 and SYS_READY=0 on that same edge; counters clear.
REQ-025 A STAGE_ACK bit for an unreleased stage shall be ignored.
REQ-026 Counters shall be 16 bits, shall saturate, and shall never wrap.
REQ-027 Latency: STAGE_RESET_N[0] rises SYNC_STAGES+STAGE_DELAY+1 cycles after the first CLK edge sampling FABRIC_RESET_N=1.

Reset
REQ-028 RST=1 shall force IDLE, STAGE_RESET_N=0, SYS_READY=0, FAULT=0, CUR_STAGE=0, counters=0, and synchronizer flops=0, on the next CLK edge.
REQ-029 RST shall take priority over every other input, including mid-sequence and in FAULT.

Structure
REQ-030 Package reset_seq_pkg shall hold the state enum, the counter width (16), and the default parameter constants.
REQ-031 Sub-module reset_sync shall implement the SYNC_STAGES-deep synchronizer; the sequencer shall instantiate it once.
REQ-032 Target size is 120-400 RTL lines, with no latches and no combinational outputs.

Verification (NUM_STAGES=4, STAGE_DELAY=16, ACK_TIMEOUT=255, SYNC_STAGES=2)
REQ-033 Nominal: release RST, FABRIC_RESET_N=1, each ACK after 3 cycles -> STAGE_RESET_N goes 0001,0011,0111,1111; stage 0 at cycle 19; SYS_READY=1; FAULT=0.
REQ-034 Timeout: withhold STAGE_ACK[2] -> FAULT=1 exactly 255 cycles after stage 2 release; STAGE_RESET_N=0000; FAULT holds until FABRIC_RESET_N=0.
REQ-035 Mid-sequence abort: drive FABRIC_RESET_N=0 during GAP after stage 1 -> STAGE_RESET_N=0000 within 3 cycles; full resequence after FABRIC_RESET_N=1.
REQ-036 RUN acknowledge loss: drop STAGE_ACK[3] in RUN -> next cycle FAULT=1, SYS_READY=0, STAGE_RESET_N=0000.
REQ-037 Boundary: ACK at counter expiry is accepted (no FAULT); early ACK on unreleased stage 3 is ignored.
REQ-038 RST pulse in WAIT_ACK of stage 2 -> all outputs at reset values on the next edge.
